// File: rtl/lz77_pkg.sv
// Shared LZ77 constants, token type and decoder state encoding,
// used by both the encoder and decoder stages.
package lz77_pkg;

    localparam int          SEARCH_DEPTH = 9;
    localparam int          OFS_W        = 4;
    localparam int          LEN_W        = 3;
    localparam logic [7:0]  END_CHAR     = 8'h24;
    localparam int          CNT_W        = $clog2(SEARCH_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        LIT  = 2'd2,
        DONE = 2'd3
    } dec_state_e;

    typedef struct packed {
        logic [OFS_W-1:0] offset;
        logic [LEN_W-1:0] match_len;
        logic [7:0]       char_nxt;
    } lz77_token_t;

    // Out-of-range offsets read the oldest entry instead of wrapping.
    function automatic logic [OFS_W-1:0] clamp_ofs(input logic [OFS_W-1:0] ofs);
        return (ofs > OFS_W'(SEARCH_DEPTH - 1)) ? OFS_W'(SEARCH_DEPTH - 1) : ofs;
    endfunction

endpackage

// File: rtl/lz77_hist_buf.sv
// History shift register of decoded characters: entry 0 is the most recent,
// with a combinational read port addressed by distance.
module lz77_hist_buf
    import lz77_pkg::*;
#(
    parameter int DEPTH = SEARCH_DEPTH,
    parameter int IDX_W = OFS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en_i,
    input  logic [7:0]       din_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [7:0]       rd_data_o
);

    logic [7:0] hist_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= 8'h00;
        end else if (shift_en_i) begin
            hist_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
        end
    end

    assign rd_data_o = hist_q[rd_idx_i];

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 token decoder: expands (offset, match_len, char_nxt) into one char/cycle.
// Define LZ77_DEC_CHECK_EN to add the sticky err output for bad back-references.
module lz77_decoder
    import lz77_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OFS_W-1:0] offset,
    input  logic [LEN_W-1:0] match_len,
    input  logic [7:0]       char_nxt,
    output logic             out_valid,
    output logic [7:0]       out_char,
    output logic             finish
`ifdef LZ77_DEC_CHECK_EN
    ,output logic            err
`endif
);

    dec_state_e       state_q, state_d;
    logic [OFS_W-1:0] ofs_q, ofs_d;
    logic [7:0]       chr_q, chr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_char_q, out_char_d;
    logic             finish_q, finish_d;

    lz77_token_t      tok_in;
    logic             accept;
    logic             shift_en;
    logic [7:0]       shift_din;
    logic [7:0]       hist_rd;

    assign tok_in   = '{offset: offset, match_len: match_len, char_nxt: char_nxt};
    assign in_ready = (state_q == IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    lz77_hist_buf #(
        .DEPTH (SEARCH_DEPTH),
        .IDX_W (OFS_W)
    ) u_hist (
        .clk        (clk),
        .rst        (reset),
        .shift_en_i (shift_en),
        .din_i      (shift_din),
        .rd_idx_i   (clamp_ofs(ofs_q)),
        .rd_data_o  (hist_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ofs_q       <= '0;
            chr_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ofs_q       <= ofs_d;
            chr_q       <= chr_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            finish_q    <= finish_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (tok_in.match_len != '0) ? COPY : LIT;
            COPY: if (rem_q == LEN_W'(1)) state_d = LIT;
            LIT:  state_d = (chr_q == END_CHAR) ? DONE : IDLE;
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Each copied char is shifted back in, so the same offset keeps pointing
    // at the next source char and overlapping matches decode naturally.
    always_comb begin
        ofs_d       = ofs_q;
        chr_d       = chr_q;
        rem_d       = rem_q;
        out_valid_d = 1'b0;
        out_char_d  = out_char_q;
        finish_d    = finish_q;
        shift_en    = 1'b0;
        shift_din   = hist_rd;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ofs_d = tok_in.offset;
                    chr_d = tok_in.char_nxt;
                    rem_d = tok_in.match_len;
                end
            end
            COPY: begin
                out_valid_d = 1'b1;
                out_char_d  = hist_rd;
                shift_en    = 1'b1;
                rem_d       = rem_q - LEN_W'(1);
            end
            LIT: begin
                if (chr_q != END_CHAR) begin
                    out_valid_d = 1'b1;
                    out_char_d  = chr_q;
                    shift_en    = 1'b1;
                    shift_din   = chr_q;
                end else begin
                    finish_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign finish    = finish_q;

`ifdef LZ77_DEC_CHECK_EN
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (shift_en && (int'(cnt_q) < SEARCH_DEPTH)) cnt_q <= cnt_q + CNT_W'(1);
            if (accept && ((int'(tok_in.offset) > SEARCH_DEPTH - 1) ||
                           ((tok_in.match_len != '0) && (int'(tok_in.offset) >= int'(cnt_q)))))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_lz77_decoder.sv
// Directed bench for lz77_decoder: token table plus reset, stall and end-marker sequences.
module tb_lz77_decoder;
    import lz77_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] offset = '0;
    logic [2:0] match_len = '0;
    logic [7:0] char_nxt = '0;
    logic       out_valid;
    logic [7:0] out_char;
    logic       finish;
`ifdef LZ77_DEC_CHECK_EN
    logic       err;
`endif

    int total = 0;
    int bad = 0;

    lz77_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .offset    (offset),
        .match_len (match_len),
        .char_nxt  (char_nxt),
        .out_valid (out_valid),
        .out_char  (out_char),
        .finish    (finish)
`ifdef LZ77_DEC_CHECK_EN
        ,.err      (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      o;
        logic [2:0]      l;
        logic [7:0]      c;
        logic [0:7][7:0] e;
        string           nm;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one token in IDLE, then check every emitted char (or finish on END_CHAR).
    task automatic run_tok(input logic [3:0] o, input logic [2:0] l, input logic [7:0] c,
                           input logic [0:7][7:0] e, input string nm);
        offset = o; match_len = l; char_nxt = c; in_valid = 1'b1;
        chk({nm, ".rdy"}, 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        chk({nm, ".acc_ov"}, 32'(out_valid), 32'd0);
        for (int k = 0; k <= int'(l); k++) begin
            tick;
            if (k == int'(l) && c == END_CHAR) begin
                chk({nm, ".end_ov"}, 32'(out_valid), 32'd0);
                chk({nm, ".fin"}, 32'(finish), 32'd1);
            end else begin
                chk($sformatf("%s.ov%0d", nm, k), 32'(out_valid), 32'd1);
                chk($sformatf("%s.ch%0d", nm, k), 32'(out_char), 32'(e[k]));
                chk($sformatf("%s.fin%0d", nm, k), 32'(finish), 32'd0);
            end
        end
    endtask

    initial begin
        vec_t            tv[5];
        logic [0:7][7:0] e;

        tv[0] = '{4'd0, 3'd0, "a", "a.......", "t1a"};
        tv[1] = '{4'd0, 3'd0, "b", "b.......", "t1b"};
        tv[2] = '{4'd1, 3'd2, "c", "abc.....", "t1c"};
        tv[3] = '{4'd0, 3'd0, "x", "x.......", "t2x"};
        tv[4] = '{4'd0, 3'd7, "y", "xxxxxxxy", "t2ovl"};

        // reset state
        tick; tick;
        chk("rst.ov", 32'(out_valid), 32'd0);
        chk("rst.ch", 32'(out_char), 32'd0);
        chk("rst.fin", 32'(finish), 32'd0);
        chk("rst.rdy", 32'(in_ready), 32'd0);
`ifdef LZ77_DEC_CHECK_EN
        chk("rst.err", 32'(err), 32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("rel.rdy", 32'(in_ready), 32'd1);

`ifdef LZ77_DEC_CHECK_EN
        e = "?z......";
        e[0] = 8'h00;
        run_tok(4'd3, 3'd1, "z", e, "t6");
        chk("t6.err", 32'(err), 32'd1);
        tick;
        chk("t6.err_hold", 32'(err), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        chk("t6.err_clr", 32'(err), 32'd0);
`endif

        for (int i = 0; i < 5; i++) run_tok(tv[i].o, tv[i].l, tv[i].c, tv[i].e, tv[i].nm);

        // upstream stall: no output and no history movement
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("stall.ov%0d", i), 32'(out_valid), 32'd0);
            chk($sformatf("stall.rdy%0d", i), 32'(in_ready), 32'd1);
        end
        run_tok(4'd2, 3'd3, "!", "xxy!....", "t5");

        // reset in the middle of a len-5 copy
        offset = 4'd0; match_len = 3'd5; char_nxt = "k"; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick; tick; tick;
        chk("t4.ov3", 32'(out_valid), 32'd1);
        chk("t4.ch3", 32'(out_char), 32'h21);
        reset = 1'b1;
        #1;
        chk("t4.rst_ov", 32'(out_valid), 32'd0);
        chk("t4.rst_fin", 32'(finish), 32'd0);
        chk("t4.rst_rdy", 32'(in_ready), 32'd0);
        tick;
        reset = 1'b0;
        #1;
        chk("t4.rel_rdy", 32'(in_ready), 32'd1);
        // oversize offset clamps to the oldest entry, which is zero after reset
        e = "?m......";
        e[0] = 8'h00;
        run_tok(4'd15, 3'd1, "m", e, "t4hist");

        // end marker with a copy before it
        run_tok(4'd0, 3'd0, "q", "q.......", "t3q");
        run_tok(4'd0, 3'd2, 8'h24, "qq......", "t3end");
        offset = 4'd0; match_len = 3'd0; char_nxt = "z"; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("done.rdy%0d", i), 32'(in_ready), 32'd0);
            chk($sformatf("done.ov%0d", i), 32'(out_valid), 32'd0);
            chk($sformatf("done.fin%0d", i), 32'(finish), 32'd1);
        end
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lz77_decoder.md
Name: lz77_decoder

Overview:
- Consumes the (offset, match_len, char_nxt) token stream produced by the LZ77 encoder stage and reconstructs the original character stream, one character per cycle.
- Keeps a 9-entry search buffer of already-decoded characters, mirroring the encoder's window.
- Stops and raises finish when the end-marker character (0x24, '$') arrives as char_nxt.

Parameters:
SEARCH_DEPTH, 9, number of history entries; valid offsets are 0..SEARCH_DEPTH-1
OFS_W, 4, offset width
LEN_W, 3, match_len width; max match 7
END_CHAR, 8'h24, char_nxt value that terminates the stream

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  token present on offset/match_len/char_nxt
in_ready  out  1  decoder accepts a token this cycle
offset  in  OFS_W  distance into history; 0 = most recent char
match_len  in  LEN_W  number of chars copied from history
char_nxt  in  8  literal following the copy
out_valid  out  1  out_char valid this cycle
out_char  out  8  decoded character
finish  out  1  end marker consumed; sticky until reset

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state to IDLE; all history entries to 0; emitted-count to 0.
  - out_valid=0, out_char=0, finish=0, in_ready=0 during reset.
- States: IDLE, COPY, LIT, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid & in_ready: register offset, match_len, char_nxt; set remaining=match_len.
  - Go to COPY if match_len!=0, else LIT.
- COPY:
  - in_ready=0.
  - Each cycle: out_char <= hist[offset_reg]; out_valid <= 1.
  - Shift history: hist[i] <= hist[i-1], hist[0] <= emitted char.
  - Because of the shift, the same index offset_reg always addresses the next copy source, so self-overlapping matches (offset_reg < match_len) decode correctly.
  - Decrement remaining; on the cycle remaining reaches 1, go to LIT.
- LIT:
  - If char_nxt_reg != END_CHAR: emit char_nxt_reg with a history shift, then return to IDLE.
  - If char_nxt_reg == END_CHAR: do not emit it (out_valid=0), set finish=1, go to DONE.
- DONE:
  - in_ready=0, out_valid=0, finish held at 1.
  - Only reset leaves DONE. in_valid is ignored.
- Timing:
  - Token accepted in cycle N; first out_valid appears at the edge ending cycle N+1 (registered outputs).
  - A token occupies match_len+2 cycles: 1 accept cycle plus match_len+1 emit cycles.
  - out_valid is 0 in accept cycles.
- out_valid is a single-cycle qualifier per char. There is no output backpressure; the downstream must take one char per cycle.
- Widths:
  - remaining is LEN_W bits.
  - emitted-count saturates at SEARCH_DEPTH; it is used only by the optional check.
- Boundaries:
  - offset values above SEARCH_DEPTH-1 are illegal upstream. Index with offset_reg modulo-free, clamped to SEARCH_DEPTH-1.
  - A match_len=0 token emits exactly one char (the literal).
  - An END_CHAR token with match_len>0 still emits its copied chars before finishing.
  - in_valid without in_ready leaves the token held by the upstream; no state change.

Optional Feature:
- Macro: LZ77_DEC_CHECK_EN.
- Defined:
  - Adds output port err (1 bit, reset 0, sticky).
  - err is set at token acceptance if offset > SEARCH_DEPTH-1, or if match_len!=0 and offset >= emitted-count (a reference to unwritten history).
  - Decoding continues unchanged.
- Undefined: no err port, no check logic, and emitted-count is removed.

Decomposition:
- Shared package lz77_pkg holds:
  - SEARCH_DEPTH, OFS_W, LEN_W, END_CHAR constants, used by both encoder and decoder.
  - The state enum.
  - A token struct {offset, match_len, char_nxt}.
- One sub-module, lz77_hist_buf: SEARCH_DEPTH×8 shift register with shift-in enable and a read index port.
- The FSM and counters stay in lz77_decoder.

Test Plan:
1. Tokens (0,0,'a'),(0,0,'b'),(1,2,'c') -> out_char stream "a","b","a","b","c" on 5 out_valid pulses; finish=0.
2. Overlap: (0,0,'x'),(0,7,'y') -> "x" then seven "x" then "y"; 8 consecutive out_valid cycles for the second token.
3. End marker: (0,0,'q'),(0,2,8'h24) -> "q","q","q" then finish=1 one cycle after the last char; in_ready stays 0 thereafter.
4. Reset mid-COPY: assert reset during the 3rd char of a len-5 copy -> out_valid=0, finish=0, in_ready=0 immediately; after release, in_ready=1 and history reads 0.
5. Upstream stall: hold in_valid=0 for 4 cycles between tokens -> out_valid low, no history change; the next token decodes correctly against the prior history.
6. With LZ77_DEC_CHECK_EN: first token (3,1,'z') -> err=1 at acceptance and stays 1; out_char "0x00","z".
